// File: rtl/ssc_clk_pkg.sv
// Shared types and defaults for the PLL clock/reset sequencer.
// Imported by ssc_clk_sequencer and its testbench.
package ssc_clk_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int unsigned STABLE_CYCLES_DEF = 4096;
    localparam int unsigned HOLD_CYCLES_DEF   = 16;
    localparam int unsigned DIV_DEF           = 16;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-stage synchronizer with asynchronous active-low clear.
// Ports: clk, rst_n (async clear), d (async input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ssc_clk_sequencer.sv
// PLL lock sequencer: synchronous reset release, baud enable, sticky lock-loss flag.
// Ports: clk, reset_n, locked_in, lost_clr -> sys_reset_n, run, ce_baud, lock_lost.
module ssc_clk_sequencer
    import ssc_clk_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned DIV           = DIV_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic locked_in,
    input  logic lost_clr,
    output logic sys_reset_n,
    output logic run,
    output logic ce_baud,
    output logic lock_lost
);

    // One shared counter serves both the stable and hold intervals.
    localparam int unsigned CNT_MAX = max_u(STABLE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned DW      = $clog2(DIV);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);

    logic          locked_sync;
    logic          locked_s_q;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          sys_reset_n_q;
    logic          sys_reset_n_d;
    logic          ce_baud_q;
    logic          ce_baud_d;
    logic          lock_lost_q;
    logic          lock_lost_d;
    logic          stay_run;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (locked_in),
        .q     (locked_sync)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;

        if (lost_clr) begin
            lock_lost_d = 1'b0;
        end

        unique case (state_q)
            ST_WAIT: begin
                cnt_d = '0;
                if (locked_s_q) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!locked_s_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
                    state_d     = ST_HOLD;
                    // Set is applied after clear, so set wins.
                    lock_lost_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Relock is deliberately ignored until the hold expires.
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Divider and baud enable only advance while RUN persists, so the
    // leaving edge drops ce_baud together with sys_reset_n.
    always_comb begin
        stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
        div_d    = '0;
        if (stay_run) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        ce_baud_d     = stay_run && (div_q == DIV_LAST);
        sys_reset_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_s_q    <= 1'b0;
            state_q       <= ST_WAIT;
            cnt_q         <= '0;
            div_q         <= '0;
            sys_reset_n_q <= 1'b0;
            ce_baud_q     <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            // Local copy of the synchronized flag feeding the FSM decode.
            locked_s_q    <= locked_sync;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            sys_reset_n_q <= sys_reset_n_d;
            ce_baud_q     <= ce_baud_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign sys_reset_n = sys_reset_n_q;
    assign run         = sys_reset_n_q;
    assign ce_baud     = ce_baud_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_ssc_clk_sequencer.sv
// Directed testbench for ssc_clk_sequencer (STABLE=8, HOLD=4, DIV=16 and DIV=2).
// Edge e is the e-th rising edge after an input change made on a falling edge.
module tb_ssc_clk_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    logic locked_in;
    logic lost_clr;

    logic a_sys, a_run, a_ce, a_lost;
    logic b_sys, b_run, b_ce, b_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssc_clk_sequencer #(
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .DIV           (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .locked_in   (locked_in),
        .lost_clr    (lost_clr),
        .sys_reset_n (a_sys),
        .run         (a_run),
        .ce_baud     (a_ce),
        .lock_lost   (a_lost)
    );

    ssc_clk_sequencer #(
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .DIV           (2)
    ) dut_div2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .locked_in   (locked_in),
        .lost_clr    (lost_clr),
        .sys_reset_n (b_sys),
        .run         (b_run),
        .ce_baud     (b_ce),
        .lock_lost   (b_lost)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        locked_in = 1'b0;
        lost_clr  = 1'b0;
        step(2);
        checks++;
        if ({a_sys, a_run, a_ce, a_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a got %b exp 0000", {a_sys, a_run, a_ce, a_lost});
        end
        checks++;
        if ({b_sys, b_run, b_ce, b_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b got %b exp 0000", {b_sys, b_run, b_ce, b_lost});
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        checks++;
        if ({a_sys, a_ce, a_lost} !== 3'b000) begin
            errors++;
            $display("FAIL unlocked_idle got %b exp 000", {a_sys, a_ce, a_lost});
        end
    endtask

    task automatic test_clean_lock;
        logic es, ece, bce;
        @(negedge clk);
        locked_in = 1'b1;
        for (int e = 0; e <= 60; e++) begin
            @(posedge clk);
            #1;
            es  = (e >= 11);
            ece = (e >= 27) && ((e - 27) % 16 == 0);
            bce = (e >= 13) && ((e - 13) % 2 == 0);
            checks++;
            if ({a_sys, a_run, a_ce, a_lost} !== {es, es, ece, 1'b0}) begin
                errors++;
                $display("FAIL clean e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_ce, a_lost}, {es, es, ece, 1'b0});
            end
            checks++;
            if ({b_sys, b_ce} !== {es, bce}) begin
                errors++;
                $display("FAIL clean_div2 e=%0d got %b exp %b", e,
                         {b_sys, b_ce}, {es, bce});
            end
        end
    endtask

    task automatic test_loss_in_run;
        logic es;
        @(negedge clk);
        locked_in = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk);
            #1;
            es = (e < 3);
            checks++;
            if ({a_sys, a_run, a_lost} !== {es, es, !es}) begin
                errors++;
                $display("FAIL loss e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_lost}, {es, es, !es});
            end
            if (e >= 3) begin
                checks++;
                if (a_ce !== 1'b0) begin
                    errors++;
                    $display("FAIL loss_ce e=%0d got %b exp 0", e, a_ce);
                end
            end
        end
        @(negedge clk);
        locked_in = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            es = (e >= 11);
            checks++;
            if ({a_sys, a_run, a_ce, a_lost} !== {es, es, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL relock e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_ce, a_lost}, {es, es, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_async_reset_mid_run;
        logic es;
        checks++;
        if ({a_sys, a_lost} !== 2'b11) begin
            errors++;
            $display("FAIL pre_async got %b exp 11", {a_sys, a_lost});
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_sys, a_run, a_ce, a_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL async_a got %b exp 0000", {a_sys, a_run, a_ce, a_lost});
        end
        checks++;
        if ({b_sys, b_run, b_ce, b_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL async_b got %b exp 0000", {b_sys, b_run, b_ce, b_lost});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            es = (e >= 11);
            checks++;
            if ({a_sys, a_run, a_ce, a_lost} !== {es, es, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL async_rel e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_ce, a_lost}, {es, es, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_sticky_clear;
        logic es;
        @(negedge clk);
        locked_in = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            if (e == 3) begin
                @(negedge clk);
                lost_clr = 1'b1;
            end
            if (e == 4) begin
                @(negedge clk);
                lost_clr = 1'b0;
            end
            @(posedge clk);
            #1;
            es = (e < 3);
            checks++;
            if ({a_sys, a_lost} !== {es, !es}) begin
                errors++;
                $display("FAIL sticky_same e=%0d got %b exp %b", e,
                         {a_sys, a_lost}, {es, !es});
            end
        end
        @(negedge clk);
        lost_clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_lost !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr got %b exp 0", a_lost);
        end
        @(negedge clk);
        lost_clr  = 1'b0;
        locked_in = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            es = (e >= 11);
            checks++;
            if ({a_sys, a_ce, a_lost} !== {es, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sticky_relock e=%0d got %b exp %b", e,
                         {a_sys, a_ce, a_lost}, {es, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_relock_during_hold;
        logic es;
        @(negedge clk);
        locked_in = 1'b0;
        for (int e = 0; e <= 18; e++) begin
            if (e == 1) begin
                @(negedge clk);
                locked_in = 1'b1;
            end
            @(posedge clk);
            #1;
            es = (e < 3) || (e >= 16);
            checks++;
            if ({a_sys, a_run, a_lost} !== {es, es, (e >= 3)}) begin
                errors++;
                $display("FAIL hold_relock e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_lost}, {es, es, (e >= 3)});
            end
            if (e >= 3) begin
                checks++;
                if (a_ce !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_ce e=%0d got %b exp 0", e, a_ce);
                end
            end
        end
    endtask

    task automatic test_glitch_in_count;
        logic es;
        reset_n   = 1'b0;
        locked_in = 1'b0;
        lost_clr  = 1'b0;
        step(2);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        @(negedge clk);
        locked_in = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            if (e == 6) begin
                @(negedge clk);
                locked_in = 1'b0;
            end
            if (e == 7) begin
                @(negedge clk);
                locked_in = 1'b1;
            end
            @(posedge clk);
            #1;
            es = (e >= 18);
            checks++;
            if ({a_sys, a_run, a_ce, a_lost} !== {es, es, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL glitch e=%0d got %b exp %b", e,
                         {a_sys, a_run, a_ce, a_lost}, {es, es, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_div_wrap;
        logic prev;
        int   pulses;
        prev   = b_ce;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({b_sys, b_ce} !== {1'b1, ~prev}) begin
                errors++;
                $display("FAIL div2 i=%0d got %b exp %b", i,
                         {b_sys, b_ce}, {1'b1, ~prev});
            end
            if (b_ce === 1'b1) pulses++;
            prev = b_ce;
        end
        checks++;
        if (pulses != 500) begin
            errors++;
            $display("FAIL div2_pulses got %0d exp 500", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_in_run();
        test_async_reset_mid_run();
        test_sticky_clear();
        test_relock_during_hold();
        test_glitch_in_count();
        test_div_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
